// File: rtl/star_board_engine.sv
// star_board_engine
//   Owns the 8x8 star board: fills it from an LFSR after reset, services
//   eliminate requests, clears matching horizontal/vertical runs through the
//   cursor, applies gravity, optionally refills, and keeps a saturating score.
//
//   Optional feature macro: STAR_REFILL_EN (defined = refill empty cells after
//   gravity; undefined = gravity goes straight to DONE and the board drains).
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     elim_req, cur_x, cur_y   eliminate request at (row cur_x, column cur_y)
//     wr_en, wr_row, wr_col,
//     wr_color                 debug cell write (IDLE only, 6/7 stored as 0)
//     rd_row, rd_col, rd_color combinational display read port
//     busy                     high in every state except IDLE
//     done                     one-cycle pulse when a request completes
//     cleared                  cells cleared by the last request
//     score                    saturating running total of cleared
module star_board_engine #(
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int unsigned MIN_RUN = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        elim_req,
   input  logic [2:0]  cur_x,
   input  logic [2:0]  cur_y,
   input  logic        wr_en,
   input  logic [2:0]  wr_row,
   input  logic [2:0]  wr_col,
   input  logic [2:0]  wr_color,
   input  logic [2:0]  rd_row,
   input  logic [2:0]  rd_col,
   output logic [2:0]  rd_color,
   output logic        busy,
   output logic        done,
   output logic [6:0]  cleared,
   output logic [15:0] score
);

   localparam logic [2:0] S_INIT    = 3'd0;
   localparam logic [2:0] S_IDLE    = 3'd1;
   localparam logic [2:0] S_SCAN_H  = 3'd2;
   localparam logic [2:0] S_SCAN_V  = 3'd3;
   localparam logic [2:0] S_CLEAR   = 3'd4;
   localparam logic [2:0] S_GRAVITY = 3'd5;
   localparam logic [2:0] S_REFILL  = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   localparam logic [3:0] RUN_MIN = 4'(MIN_RUN);

   logic [2:0]  state;
   logic [2:0]  board [64];        // index = {row, col}
   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic [2:0]  new_color;
   logic [5:0]  ptr;               // raster pointer for INIT / REFILL
   logic [2:0]  cx, cy, color;     // latched cursor and its colour
   logic        scan_right;        // second half of a scan walk
   logic [2:0]  h_lo, h_hi, v_lo, v_hi;
   logic [2:0]  g_row, g_row_up;
   logic        pass_swap;

   logic        left_ok, right_ok, up_ok, down_ok;
   logic [3:0]  h_len, v_len;
   logic        mark_h, mark_v;
   logic [4:0]  clr_cnt;
   logic [16:0] score_sum;
   logic [63:0] clr_mask;
   logic [7:0]  swap;
   logic [2:0]  cur_cell;

   assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign new_color = (lfsr[2:0] % 3'd5) + 3'd1;
   assign cur_cell  = board[{cur_x, cur_y}];
   assign g_row_up  = g_row - 3'd1;

   assign rd_color  = board[{rd_row, rd_col}];
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   // The walk pointers double as the run bounds: h_lo/v_lo move during the
   // first half of a scan, h_hi/v_hi during the second half.
   always_comb begin
      left_ok  = (h_lo != 3'd0) && (board[{cx, 3'(h_lo - 3'd1)}] == color);
      right_ok = (h_hi != 3'd7) && (board[{cx, 3'(h_hi + 3'd1)}] == color);
      up_ok    = (v_lo != 3'd0) && (board[{3'(v_lo - 3'd1), cy}] == color);
      down_ok  = (v_hi != 3'd7) && (board[{3'(v_hi + 3'd1), cy}] == color);
   end

   always_comb begin
      h_len     = {1'b0, h_hi} - {1'b0, h_lo} + 4'd1;
      v_len     = {1'b0, v_hi} - {1'b0, v_lo} + 4'd1;
      mark_h    = (h_len >= RUN_MIN);
      mark_v    = (v_len >= RUN_MIN);
      // The cursor cell belongs to both runs; count it once.
      clr_cnt   = (mark_h ? {1'b0, h_len} : 5'd0)
                + (mark_v ? {1'b0, v_len} : 5'd0)
                - {4'd0, (mark_h && mark_v)};
      score_sum = {1'b0, score} + {12'd0, clr_cnt};
   end

   always_comb begin
      clr_mask = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         clr_mask[i] = (mark_h && (3'(i / 8) == cx) &&
                        (3'(i % 8) >= h_lo) && (3'(i % 8) <= h_hi)) ||
                       (mark_v && (3'(i % 8) == cy) &&
                        (3'(i / 8) >= v_lo) && (3'(i / 8) <= v_hi));
      end
   end

   always_comb begin
      swap = '0;
      for (int unsigned c = 0; c < 8; c++) begin
         swap[c] = (board[{g_row, 3'(c)}] == 3'd0) &&
                   (board[{g_row_up, 3'(c)}] != 3'd0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_INIT;
         lfsr       <= SEED;
         ptr        <= '0;
         cx         <= '0;
         cy         <= '0;
         color      <= '0;
         scan_right <= 1'b0;
         h_lo       <= '0;
         h_hi       <= '0;
         v_lo       <= '0;
         v_hi       <= '0;
         g_row      <= 3'd7;
         pass_swap  <= 1'b0;
         cleared    <= '0;
         score      <= '0;
         for (int unsigned i = 0; i < 64; i++) board[i] <= '0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
         case (state)
            S_INIT: begin
               board[ptr] <= new_color;
               ptr        <= ptr + 6'd1;
               if (ptr == 6'd63) state <= S_IDLE;
            end
            S_IDLE: begin
               if (elim_req) begin
                  cx         <= cur_x;
                  cy         <= cur_y;
                  color      <= cur_cell;
                  h_lo       <= cur_y;
                  h_hi       <= cur_y;
                  v_lo       <= cur_x;
                  v_hi       <= cur_x;
                  scan_right <= 1'b0;
                  if (cur_cell == 3'd0) begin
                     cleared <= '0;
                     state   <= S_DONE;
                  end else begin
                     state   <= S_SCAN_H;
                  end
               end else if (wr_en) begin
                  board[{wr_row, wr_col}] <= (wr_color > 3'd5) ? 3'd0 : wr_color;
               end
            end
            S_SCAN_H: begin
               if (!scan_right) begin
                  if (left_ok) h_lo <= h_lo - 3'd1;
                  else         scan_right <= 1'b1;
               end else if (right_ok) begin
                  h_hi <= h_hi + 3'd1;
               end else begin
                  scan_right <= 1'b0;
                  state      <= S_SCAN_V;
               end
            end
            S_SCAN_V: begin
               if (!scan_right) begin
                  if (up_ok) v_lo <= v_lo - 3'd1;
                  else       scan_right <= 1'b1;
               end else if (down_ok) begin
                  v_hi <= v_hi + 3'd1;
               end else begin
                  scan_right <= 1'b0;
                  if (mark_h || mark_v) begin
                     state <= S_CLEAR;
                  end else begin
                     cleared <= '0;
                     state   <= S_DONE;
                  end
               end
            end
            S_CLEAR: begin
               for (int unsigned i = 0; i < 64; i++) begin
                  if (clr_mask[i]) board[i] <= '0;
               end
               cleared   <= {2'b00, clr_cnt};
               score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
               g_row     <= 3'd7;
               pass_swap <= 1'b0;
               state     <= S_GRAVITY;
            end
            S_GRAVITY: begin
               for (int unsigned c = 0; c < 8; c++) begin
                  if (swap[c]) begin
                     board[{g_row, 3'(c)}]    <= board[{g_row_up, 3'(c)}];
                     board[{g_row_up, 3'(c)}] <= '0;
                  end
               end
               if (g_row == 3'd1) begin
                  if (pass_swap || (|swap)) begin
                     g_row     <= 3'd7;
                     pass_swap <= 1'b0;
                  end else begin
`ifdef STAR_REFILL_EN
                     ptr   <= '0;
                     state <= S_REFILL;
`else
                     state <= S_DONE;
`endif
                  end
               end else begin
                  g_row     <= g_row_up;
                  pass_swap <= pass_swap | (|swap);
               end
            end
`ifdef STAR_REFILL_EN
            S_REFILL: begin
               if (board[ptr] == 3'd0) board[ptr] <= new_color;
               ptr <= ptr + 6'd1;
               if (ptr == 6'd63) state <= S_DONE;
            end
`endif
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/star_board_engine.md
# star_board_engine

Owns the 8x8 star board for the game: fills it at reset, services eliminate requests from the cursor/operate stage, clears matching runs, applies gravity, refills, and keeps score. Sits directly upstream of the VGA display path, which reads cell colours through a combinational read port. Colour codes: 0 empty, 1 red, 2 green, 3 blue, 4 yellow, 5 purple; 6 and 7 are never stored.

## Interface
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero.
- `MIN_RUN`, 3, minimum same-colour run length that clears, range 2..8.

- `clk` in 1: system clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `elim_req` in 1: eliminate request at (`cur_x`, `cur_y`); sampled only in IDLE.
- `cur_x` in 3: cursor row, 0 = top.
- `cur_y` in 3: cursor column, 0 = left.
- `wr_en` in 1: debug cell write; accepted only in IDLE, lower priority than `elim_req`.
- `wr_row`, `wr_col` in 3 each: debug write address.
- `wr_color` in 3: debug write data; values 6/7 are stored as 0.
- `rd_row`, `rd_col` in 3 each: display read address.
- `rd_color` out 3: combinational colour of board[`rd_row`][`rd_col`].
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a request completes, accepted or rejected.
- `cleared` out 7: cells cleared by the last request, held until the next `done`.
- `score` out 16: running total of `cleared`, saturating at 16'hFFFF.

## Operation
- States: INIT, IDLE, SCAN_H, SCAN_V, CLEAR, GRAVITY, REFILL, DONE.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances every cycle outside reset.
  - New colour = (lfsr[2:0] mod 5) + 1.
- INIT: writes one cell per cycle in raster order (row-major, 0..63) from the LFSR, then goes to IDLE.
- IDLE:
  - `elim_req` latches the cursor.
  - If the cursor cell is 0, go straight to DONE with `cleared` = 0 (reject).
  - Otherwise go to SCAN_H.
- SCAN_H: a pointer walks left from the cursor one cell per cycle while the colour matches, then walks right. Result is run length H, which includes the cursor cell.
- SCAN_V: same walk upward, then downward, giving run length V.
- Clear decision:
  - Horizontal run is marked if H >= MIN_RUN; vertical run is marked if V >= MIN_RUN.
  - Count = sum of marked runs, minus 1 if both are marked (the shared cursor cell).
  - If nothing is marked, go to DONE with `cleared` = 0 and leave the board unchanged.
- CLEAR: takes one cycle. Writes 0 to all marked cells, loads `cleared`, and adds to `score` with saturation.
- GRAVITY:
  - Each cycle processes row r, stepping r = 7 down to 1, across all 8 columns in parallel.
  - In a column, if cell[r] == 0 and cell[r-1] != 0, the two cells swap.
  - A pass is 7 cycles. Passes repeat until one pass makes no swap.
- REFILL: scans all 64 cells in raster order, one per cycle. Each 0 cell gets an LFSR colour.
- DONE: asserts `done` for one cycle, then returns to IDLE.
- Simultaneous events:
  - `elim_req` and `wr_en` in the same IDLE cycle: the request wins and the write is dropped.
  - Requests and writes while `busy` is high are ignored; nothing is queued.

## Timing
- Reset values:
  - board all 0; `score` = 0; `cleared` = 0; `done` = 0; `busy` = 1; LFSR = SEED; state INIT.
- Reset asserted mid-operation aborts immediately. After release, INIT runs again.
- INIT takes 64 cycles after `rst` deasserts. `busy` falls on cycle 65.
- `rd_color` has zero latency and reflects the registered board. A debug write is visible the cycle after `wr_en`.
- Reject latency:
  - Empty cursor cell: `done` occurs 2 cycles after `elim_req` (IDLE to DONE).
  - No run: `done` occurs after SCAN_H + SCAN_V, at most 18 cycles.
- Accepted request, worst case: scans + 1 (CLEAR) + 8×7 (GRAVITY) + 64 (REFILL) + 1 (DONE).
- `score` and `cleared` update on the CLEAR cycle.

## Configuration
- `STAR_REFILL_EN` defined: the REFILL state runs as described.
- `STAR_REFILL_EN` undefined:
  - GRAVITY goes directly to DONE, so cleared cells stay 0 and the board drains.
  - INIT still fills the board.
  - The LFSR is kept and is used only by INIT.

## Test plan
- Reset, then count cycles: `busy` = 1 for exactly 64 cycles after release; afterwards every `rd_color` is in 1..5 and `score` = 0.
- Debug-load row 7 as 2,2,2,1,1,3,4,5 and row 6 as all 4; request at (7,1):
  - `cleared` = 3, `score` = 3.
  - After `done`, cells (7,0..2) = 4 (from gravity), and with refill enabled row 6 cols 0..2 are non-zero.
- Debug-load a plus shape of colour 5 centred at (4,4), H = 3 and V = 3, with all other cells 1 in a checkerboard with 2; request at (4,4): `cleared` = 5.
- Request on a cell with no run (H = V = 1): `done` pulses, `cleared` = 0, board is bit-identical and `score` is unchanged.
- Preload `score` near saturation by repeated 8-cell clears, or by force in sim, to 16'hFFFE; a 3-cell clear leaves `score` = 16'hFFFF.
- Assert `rst` during GRAVITY: all outputs return to reset values within the same cycle, and INIT completes 64 cycles after release.
